// File: rtl/palette_writer_if.sv
// Host write bus and palette RAM write port for palette_writer.
// The master modport is the host side; the slave modport is the writer.
interface palette_writer_if;
  logic        idx_wr_i;
  logic [7:0]  idx_data_i;
  logic        col_wr_i;
  logic [15:0] col_data_i;
  logic        blank_i;
  logic        ovf_clr_i;
  logic        full_o;
  logic        busy_o;
  logic        overflow_o;
  logic        pal_wr_en_o;
  logic [7:0]  pal_wr_addr_o;
  logic [15:0] pal_wr_data_o;

  modport master (
    output idx_wr_i, idx_data_i, col_wr_i, col_data_i, blank_i, ovf_clr_i,
    input  full_o, busy_o, overflow_o, pal_wr_en_o, pal_wr_addr_o, pal_wr_data_o
  );

  modport slave (
    input  idx_wr_i, idx_data_i, col_wr_i, col_data_i, blank_i, ovf_clr_i,
    output full_o, busy_o, overflow_o, pal_wr_en_o, pal_wr_addr_o, pal_wr_data_o
  );
endinterface

// File: rtl/palette_writer.sv
// Palette RAM write front end: auto-incrementing index, {addr,colour} FIFO,
// and a drain that writes the palette one entry per cycle (blanking only by default).
module palette_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter bit BLANK_ONLY = 1'b1
) (
  input  logic             clk,
  input  logic             reset_i,
  palette_writer_if.slave  bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] colour;
  } entry_t;

  entry_t          fifo_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      idx_q, idx_d;
  logic            ovf_q, ovf_d;
  logic            wr_en_q, wr_en_d;
  logic [7:0]      wr_addr_q, wr_addr_d;
  logic [15:0]     wr_data_q, wr_data_d;

  logic            pop;
  logic            push;
  logic            drop;
  logic [7:0]      push_idx;
  entry_t          head;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return p + AW'(1);
  endfunction

  assign head     = fifo_q[rd_ptr_q];
  assign pop      = (cnt_q != '0) && (bus.blank_i || !BLANK_ONLY);
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign push     = bus.col_wr_i && ((cnt_q != DEPTH_C) || pop);
  assign drop     = bus.col_wr_i && !push;
  assign push_idx = bus.idx_wr_i ? bus.idx_data_i : idx_q;

  always_comb begin
    idx_d     = push_idx;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (push) begin
      idx_d    = push_idx + 8'd1;
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end

    if (pop) begin
      rd_ptr_d  = ptr_inc(rd_ptr_q);
      wr_en_d   = 1'b1;
      wr_addr_d = head.addr;
      wr_data_d = head.colour;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // Set has priority over clear so a drop is never lost.
    if (bus.ovf_clr_i) ovf_d = 1'b0;
    if (drop)          ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      idx_q     <= 8'h00;
      ovf_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 8'h00;
      wr_data_q <= 16'h0000;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      ovf_q     <= ovf_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Storage needs no reset: pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (push && !reset_i) begin
      fifo_q[wr_ptr_q] <= '{addr: push_idx, colour: bus.col_data_i};
    end
  end

  assign bus.full_o        = (cnt_q == DEPTH_C);
  assign bus.busy_o        = (cnt_q != '0) || wr_en_q;
  assign bus.overflow_o    = ovf_q;
  assign bus.pal_wr_en_o   = wr_en_q;
  assign bus.pal_wr_addr_o = wr_addr_q;
  assign bus.pal_wr_data_o = wr_data_q;

endmodule

// File: tb/tb_palette_writer.sv
// Directed bench for palette_writer: per-cycle vector table plus hand-written
// sequences for full-with-pop, blanking pause, reset mid-drain and overflow priority.
module tb_palette_writer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  palette_writer_if bus ();

  palette_writer #(.FIFO_DEPTH(4), .BLANK_ONLY(1'b1)) dut (
    .clk     (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iw;
    logic [7:0]  id;
    logic        cw;
    logic [15:0] cd;
    logic        bl;
    logic        clr;
    logic        en;
    logic [7:0]  addr;
    logic [15:0] data;
    logic        full;
    logic        busy;
    logic        ovf;
  } vec_t;

  vec_t tbl [30];

  function automatic vec_t mk(input logic r, input logic iw, input logic [7:0] id,
                              input logic cw, input logic [15:0] cd, input logic bl,
                              input logic clr, input logic en, input logic [7:0] addr,
                              input logic [15:0] data, input logic full,
                              input logic busy, input logic ovf);
    vec_t v;
    v.rst = r; v.iw = iw; v.id = id; v.cw = cw; v.cd = cd; v.bl = bl; v.clr = clr;
    v.en = en; v.addr = addr; v.data = data; v.full = full; v.busy = busy; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iw, input logic [7:0] id, input logic cw,
                       input logic [15:0] cd, input logic bl, input logic clr);
    rst            = r;
    bus.idx_wr_i   = iw;
    bus.idx_data_i = id;
    bus.col_wr_i   = cw;
    bus.col_data_i = cd;
    bus.blank_i    = bl;
    bus.ovf_clr_i  = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1, 0, 8'h00, 0, 16'h0000, 0, 0);
    step();
    drive(0, 0, 8'h00, 0, 16'h0000, 0, 0);
  endtask

  initial begin
    int nwr;
    logic [7:0]  exp_a;
    logic [15:0] exp_d;

    checks = 0;
    errors = 0;
    drive(1, 0, 8'h00, 0, 16'h0000, 0, 0);

    //                 rst iw id     cw cd        bl clr  en addr   data      fu bu ov
    tbl[0]  = mk(1, 0, 8'h00, 0, 16'h0000, 0, 0,  0, 8'h00, 16'h0000, 0, 0, 0);
    tbl[1]  = mk(0, 1, 8'h10, 0, 16'h0000, 1, 0,  0, 8'h00, 16'h0000, 0, 0, 0);
    tbl[2]  = mk(0, 0, 8'h00, 1, 16'h0F00, 1, 0,  0, 8'h00, 16'h0000, 0, 1, 0);
    tbl[3]  = mk(0, 0, 8'h00, 1, 16'h00F0, 1, 0,  1, 8'h10, 16'h0F00, 0, 1, 0);
    tbl[4]  = mk(0, 0, 8'h00, 1, 16'h000F, 1, 0,  1, 8'h11, 16'h00F0, 0, 1, 0);
    tbl[5]  = mk(0, 0, 8'h00, 0, 16'h0000, 1, 0,  1, 8'h12, 16'h000F, 0, 1, 0);
    tbl[6]  = mk(0, 0, 8'h00, 0, 16'h0000, 1, 0,  0, 8'h12, 16'h000F, 0, 0, 0);
    tbl[7]  = mk(0, 0, 8'h00, 1, 16'h0111, 0, 0,  0, 8'h12, 16'h000F, 0, 1, 0);
    tbl[8]  = mk(0, 0, 8'h00, 1, 16'h0222, 0, 0,  0, 8'h12, 16'h000F, 0, 1, 0);
    tbl[9]  = mk(0, 0, 8'h00, 1, 16'h0333, 0, 0,  0, 8'h12, 16'h000F, 0, 1, 0);
    tbl[10] = mk(0, 0, 8'h00, 1, 16'h0444, 0, 0,  0, 8'h12, 16'h000F, 1, 1, 0);
    tbl[11] = mk(0, 0, 8'h00, 1, 16'h0555, 0, 0,  0, 8'h12, 16'h000F, 1, 1, 1);
    tbl[12] = mk(0, 0, 8'h00, 0, 16'h0000, 1, 0,  1, 8'h13, 16'h0111, 0, 1, 1);
    tbl[13] = mk(0, 0, 8'h00, 0, 16'h0000, 1, 0,  1, 8'h14, 16'h0222, 0, 1, 1);
    tbl[14] = mk(0, 0, 8'h00, 0, 16'h0000, 1, 0,  1, 8'h15, 16'h0333, 0, 1, 1);
    tbl[15] = mk(0, 0, 8'h00, 0, 16'h0000, 1, 0,  1, 8'h16, 16'h0444, 0, 1, 1);
    tbl[16] = mk(0, 0, 8'h00, 0, 16'h0000, 1, 1,  0, 8'h16, 16'h0444, 0, 0, 0);
    tbl[17] = mk(0, 0, 8'h00, 1, 16'h0777, 0, 0,  0, 8'h16, 16'h0444, 0, 1, 0);
    tbl[18] = mk(0, 0, 8'h00, 0, 16'h0000, 1, 0,  1, 8'h17, 16'h0777, 0, 1, 0);
    tbl[19] = mk(0, 0, 8'h00, 0, 16'h0000, 1, 0,  0, 8'h17, 16'h0777, 0, 0, 0);
    tbl[20] = mk(0, 1, 8'hFF, 0, 16'h0000, 1, 0,  0, 8'h17, 16'h0777, 0, 0, 0);
    tbl[21] = mk(0, 0, 8'h00, 1, 16'h0AAA, 1, 0,  0, 8'h17, 16'h0777, 0, 1, 0);
    tbl[22] = mk(0, 0, 8'h00, 1, 16'h0555, 1, 0,  1, 8'hFF, 16'h0AAA, 0, 1, 0);
    tbl[23] = mk(0, 0, 8'h00, 1, 16'h0BBB, 1, 0,  1, 8'h00, 16'h0555, 0, 1, 0);
    tbl[24] = mk(0, 0, 8'h00, 0, 16'h0000, 1, 0,  1, 8'h01, 16'h0BBB, 0, 1, 0);
    tbl[25] = mk(0, 0, 8'h00, 0, 16'h0000, 1, 0,  0, 8'h01, 16'h0BBB, 0, 0, 0);
    tbl[26] = mk(0, 1, 8'h40, 1, 16'h0123, 1, 0,  0, 8'h01, 16'h0BBB, 0, 1, 0);
    tbl[27] = mk(0, 0, 8'h00, 1, 16'h0456, 1, 0,  1, 8'h40, 16'h0123, 0, 1, 0);
    tbl[28] = mk(0, 0, 8'h00, 0, 16'h0000, 1, 0,  1, 8'h41, 16'h0456, 0, 1, 0);
    tbl[29] = mk(0, 0, 8'h00, 0, 16'h0000, 1, 0,  0, 8'h41, 16'h0456, 0, 0, 0);

    for (int i = 0; i < 30; i++) begin
      drive(tbl[i].rst, tbl[i].iw, tbl[i].id, tbl[i].cw, tbl[i].cd, tbl[i].bl, tbl[i].clr);
      step();
      chk($sformatf("row%0d.en", i),   32'(bus.pal_wr_en_o),   32'(tbl[i].en));
      chk($sformatf("row%0d.addr", i), 32'(bus.pal_wr_addr_o), 32'(tbl[i].addr));
      chk($sformatf("row%0d.data", i), 32'(bus.pal_wr_data_o), 32'(tbl[i].data));
      chk($sformatf("row%0d.full", i), 32'(bus.full_o),        32'(tbl[i].full));
      chk($sformatf("row%0d.busy", i), 32'(bus.busy_o),        32'(tbl[i].busy));
      chk($sformatf("row%0d.ovf", i),  32'(bus.overflow_o),    32'(tbl[i].ovf));
    end

    // Full FIFO plus a simultaneous pop and push: five in-order writes, no overflow.
    do_reset();
    drive(0, 1, 8'h80, 0, 16'h0000, 0, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 8'h00, 1, 16'h0C01 + 16'(k), 0, 0);
      step();
    end
    chk("fp.full_before", 32'(bus.full_o), 32'd1);
    drive(0, 0, 8'h00, 1, 16'h0C05, 1, 0);
    step();
    chk("fp.ovf", 32'(bus.overflow_o), 32'd0);
    chk("fp.full_kept", 32'(bus.full_o), 32'd1);
    drive(0, 0, 8'h00, 0, 16'h0000, 1, 0);
    nwr = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.pal_wr_en_o) begin
        exp_a = 8'h80 + 8'(nwr);
        exp_d = 16'h0C01 + 16'(nwr);
        chk($sformatf("fp.addr%0d", nwr), 32'(bus.pal_wr_addr_o), 32'(exp_a));
        chk($sformatf("fp.data%0d", nwr), 32'(bus.pal_wr_data_o), 32'(exp_d));
        nwr++;
      end
      step();
    end
    chk("fp.count", 32'(nwr), 32'd5);
    chk("fp.ovf_end", 32'(bus.overflow_o), 32'd0);

    // Blanking drops mid-drain: writes pause and resume in order.
    do_reset();
    drive(0, 1, 8'h20, 0, 16'h0000, 0, 0);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 8'h00, 1, 16'h0D01 + 16'(k), 0, 0);
      step();
    end
    drive(0, 0, 8'h00, 0, 16'h0000, 1, 0);
    step();
    chk("bp.w0.en", 32'(bus.pal_wr_en_o), 32'd1);
    chk("bp.w0.addr", 32'(bus.pal_wr_addr_o), 32'h20);
    drive(0, 0, 8'h00, 0, 16'h0000, 0, 0);
    step();
    chk("bp.pause.en", 32'(bus.pal_wr_en_o), 32'd0);
    chk("bp.pause.busy", 32'(bus.busy_o), 32'd1);
    step();
    chk("bp.pause2.en", 32'(bus.pal_wr_en_o), 32'd0);
    drive(0, 0, 8'h00, 0, 16'h0000, 1, 0);
    step();
    chk("bp.w1.en", 32'(bus.pal_wr_en_o), 32'd1);
    chk("bp.w1.addr", 32'(bus.pal_wr_addr_o), 32'h21);
    chk("bp.w1.data", 32'(bus.pal_wr_data_o), 32'h0D02);
    step();
    chk("bp.w2.addr", 32'(bus.pal_wr_addr_o), 32'h22);
    chk("bp.w2.data", 32'(bus.pal_wr_data_o), 32'h0D03);
    step();
    chk("bp.done.en", 32'(bus.pal_wr_en_o), 32'd0);
    chk("bp.done.busy", 32'(bus.busy_o), 32'd0);

    // Reset while draining discards pending entries and the index counter.
    do_reset();
    drive(0, 1, 8'h30, 0, 16'h0000, 0, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 8'h00, 1, 16'h0E01 + 16'(k), 0, 0);
      step();
    end
    drive(0, 0, 8'h00, 0, 16'h0000, 1, 0);
    step();
    chk("rd.pulse.addr", 32'(bus.pal_wr_addr_o), 32'h30);
    drive(1, 0, 8'h00, 1, 16'h0FFF, 1, 0);
    step();
    chk("rd.en", 32'(bus.pal_wr_en_o), 32'd0);
    chk("rd.busy", 32'(bus.busy_o), 32'd0);
    chk("rd.full", 32'(bus.full_o), 32'd0);
    chk("rd.addr", 32'(bus.pal_wr_addr_o), 32'h00);
    chk("rd.data", 32'(bus.pal_wr_data_o), 32'h0000);
    drive(0, 0, 8'h00, 1, 16'h0E0E, 1, 0);
    step();
    drive(0, 0, 8'h00, 0, 16'h0000, 1, 0);
    step();
    chk("rd.after.en", 32'(bus.pal_wr_en_o), 32'd1);
    chk("rd.after.addr", 32'(bus.pal_wr_addr_o), 32'h00);
    chk("rd.after.data", 32'(bus.pal_wr_data_o), 32'h0E0E);

    // Overflow set and clear on the same edge: set wins.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 8'h00, 1, 16'h0101, 0, 0);
      step();
    end
    drive(0, 0, 8'h00, 1, 16'h0202, 0, 1);
    step();
    chk("ov.setwins", 32'(bus.overflow_o), 32'd1);
    drive(0, 0, 8'h00, 0, 16'h0000, 0, 1);
    step();
    chk("ov.clear", 32'(bus.overflow_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
